// File: rtl/debug_run_controller.sv
// debug_run_controller: host-command run/step/breakpoint sequencer driving the pipeline debug path.
// Define CYCLE_LIMIT_EN to enable the MAX_CYCLES run-budget stop.
module debug_run_controller #(
    parameter int          RESET_LEN  = 4,
    parameter logic [15:0] MAX_CYCLES = 16'd50000,
    parameter int          CNT_W      = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [7:0]       r_data,
    input  logic             rx_ready,
    output logic             rd_uart,
    input  logic             program_finished,
    input  logic [9:0]       pc,
    input  logic             dataSent,
    output logic             sendSignal,
    output logic             pipelineClkEnable,
    output logic             pipelineReset,
    output logic             clear_program_finished,
    output logic [CNT_W-1:0] cycle_count,
    output logic [1:0]       halt_cause,
    output logic             bp_valid,
    output logic [2:0]       current_state
);
    typedef enum logic [2:0] {IDLE, BP_HI, BP_LO, PRESET, RUN, STEP, SEND, WAIT_SENT} state_t;

    state_t     state;
    logic [3:0] rst_cnt;
    logic [9:0] bp;
    logic       first;
    logic       host_halt, bp_hit, limit_hit, stop, consume;

`ifdef CYCLE_LIMIT_EN
    assign limit_hit = (MAX_CYCLES != 16'd0) && (cycle_count == CNT_W'(MAX_CYCLES));
`else
    logic unused_max;
    assign unused_max = ^MAX_CYCLES;
    assign limit_hit  = 1'b0;
`endif

    assign host_halt = rx_ready && (r_data == 8'h48);
    // The first RUN cycle ignores the breakpoint so a run can resume from it.
    assign bp_hit  = bp_valid && (pc == bp) && !first;
    assign stop    = program_finished || bp_hit || limit_hit || host_halt;
    assign consume = rx_ready && (state == IDLE || state == BP_HI || state == BP_LO || state == RUN);

    assign rd_uart                = reset && consume;
    assign pipelineClkEnable      = (state == RUN && !stop) || (state == STEP && !program_finished);
    assign pipelineReset          = state == PRESET;
    assign clear_program_finished = state == PRESET && rst_cnt == 4'd0;
    assign sendSignal             = state == SEND;
    assign current_state          = state;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            rst_cnt     <= 4'd0;
            bp          <= 10'd0;
            bp_valid    <= 1'b0;
            first       <= 1'b0;
            cycle_count <= '0;
            halt_cause  <= 2'd0;
        end else begin
            if (pipelineClkEnable && cycle_count != '1)
                cycle_count <= cycle_count + 1'b1;
            case (state)
                IDLE: if (rx_ready) begin
                    if (r_data == 8'h52) begin
                        state   <= PRESET;
                        rst_cnt <= 4'd0;
                    end else if (r_data == 8'h43) begin
                        state <= RUN;
                        first <= 1'b1;
                    end else if (r_data == 8'h53) state <= STEP;
                    else if (r_data == 8'h42) state <= BP_HI;
                    else if (r_data == 8'h44) state <= SEND;
                    else if (r_data == 8'h58) bp_valid <= 1'b0;
                end
                BP_HI: if (rx_ready) begin
                    bp[9:8] <= r_data[1:0];
                    state   <= BP_LO;
                end
                BP_LO: if (rx_ready) begin
                    bp[7:0]  <= r_data;
                    bp_valid <= 1'b1;
                    state    <= IDLE;
                end
                PRESET: begin
                    cycle_count <= '0;
                    halt_cause  <= 2'd0;
                    rst_cnt     <= rst_cnt + 4'd1;
                    if (rst_cnt == 4'(RESET_LEN - 1)) state <= IDLE;
                end
                RUN: begin
                    first <= 1'b0;
                    if (stop) begin
                        halt_cause <= program_finished ? 2'd0 : bp_hit ? 2'd1 : limit_hit ? 2'd2 : 2'd3;
                        state      <= SEND;
                    end
                end
                STEP: begin
                    if (program_finished) halt_cause <= 2'd0;
                    state <= SEND;
                end
                SEND: state <= WAIT_SENT;
                WAIT_SENT: if (dataSent) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/debug_run_controller.md
Name: debug_run_controller

Overview:
Host-command sequencer for the MIPS pipeline debug path. Consumes command bytes from the UART receiver and drives the pipeline's clock-enable and reset. Runs the pipeline continuously or single-steps it, and stops on program end, PC breakpoint, cycle limit or host halt. After each stop it triggers a full debugger dump through the debug transmitter and waits for completion.

Parameters:
RESET_LEN, 4, cycles pipelineReset is held high per reset command (1..15)
MAX_CYCLES, 16'd50000, run cycle budget; 0 disables the limit
CNT_W, 16, width of cycle_count

Ports:
clock  in  1  system clock
reset  in  1  asynchronous reset, active-low
r_data  in  8  received UART byte
rx_ready  in  1  r_data valid; held until rd_uart
rd_uart  out  1  one-cycle pulse: byte consumed
program_finished  in  1  end-of-program flag from the end detector
pc  in  10  PC_IFID from the pipeline
dataSent  in  1  one-cycle pulse from the debug transmitter when the dump is complete
sendSignal  out  1  one-cycle pulse: start dump
pipelineClkEnable  out  1  pipeline advances one cycle when high
pipelineReset  out  1  pipeline and end-detector reset, active-high
clear_program_finished  out  1  one-cycle pulse clearing program_finished
cycle_count  out  CNT_W  enabled cycles since the last pipeline reset, saturating
halt_cause  out  2  0=END, 1=BREAKPOINT, 2=CYCLE_LIMIT, 3=HOST
bp_valid  out  1  breakpoint armed
current_state  out  3  state encoding, for LEDs

Behaviour:
- Reset (reset=0, async): state IDLE; all outputs 0; bp register=0; bp_valid=0; cycle_count=0; halt_cause=0.
- States: IDLE=0, BP_HI=1, BP_LO=2, PRESET=3, RUN=4, STEP=5, SEND=6, WAIT_SENT=7.
- IDLE, BP_HI, BP_LO, RUN: rd_uart pulses in the same cycle rx_ready=1 is seen. All other states leave rx bytes pending.
- IDLE command decode:
  - 0x52 'R' -> PRESET.
  - 0x43 'C' -> RUN.
  - 0x53 'S' -> STEP.
  - 0x42 'B' -> BP_HI.
  - 0x44 'D' -> SEND.
  - 0x58 'X' -> bp_valid=0, stay IDLE.
  - Any other byte: consumed, ignored.
- BP_HI: next byte bits[1:0] -> bp[9:8], then BP_LO. BP_LO: next byte -> bp[7:0], bp_valid=1, then IDLE.
- PRESET:
  - pipelineReset=1 for exactly RESET_LEN cycles.
  - clear_program_finished pulses in the first PRESET cycle.
  - cycle_count and halt_cause cleared.
  - Then IDLE. No dump.
- RUN:
  - stop = program_finished | (bp_valid & pc==bp & not first RUN cycle) | (MAX_CYCLES!=0 & cycle_count==MAX_CYCLES) | (rx_ready & r_data==0x48 'H').
  - pipelineClkEnable = !stop, combinational, in the same cycle.
  - On stop: halt_cause = first true condition in priority END > BREAKPOINT > CYCLE_LIMIT > HOST; go to SEND.
  - Non-'H' bytes during RUN are consumed and dropped.
  - The first-cycle breakpoint mask allows resuming from a breakpoint PC.
- STEP:
  - If program_finished: no enable, halt_cause=END.
  - Otherwise pipelineClkEnable=1 for exactly one cycle.
  - Then SEND.
- cycle_count: +1 in every cycle pipelineClkEnable=1; saturates at all-ones; clears only in PRESET.
- SEND: sendSignal=1 for one cycle, then WAIT_SENT.
- WAIT_SENT: hold until dataSent=1, then IDLE. A dataSent seen in any other state is ignored.
- pipelineClkEnable is never high outside RUN or STEP, and never high while pipelineReset=1.
- current_state = state encoding above.

Optional Feature:
CYCLE_LIMIT_EN:
- Defined: MAX_CYCLES stop condition active; halt_cause=2 is reachable.
- Undefined: the limit term is removed and MAX_CYCLES is unused. cycle_count still counts and saturates, and RUN stops only on END/BREAKPOINT/HOST.

Test Plan:
- Reset with RESET_LEN=4, then send 'R' -> pipelineReset high exactly 4 cycles; clear_program_finished one pulse; cycle_count=0; state returns to IDLE with no sendSignal.
- 'S' three times, each followed by a dataSent pulse -> exactly one enable cycle per step; cycle_count=3; three sendSignal pulses.
- 'B',0x00,0x05 then 'C', pc model = cycle_count -> run stops with pc=5 and no enable in that cycle; halt_cause=1; sendSignal pulses. A further 'C' advances past 5.
- MAX_CYCLES=10, 'C', no finish -> exactly 10 enable cycles; halt_cause=2. Then 'R', 'C' with program_finished rising at cycle 3 -> halt_cause=0, cycle_count=3.
- During RUN send 0x41 then 0x48 -> 0x41 consumed with run continuing; 0x48 stops the run with halt_cause=3. Program_finished and 'H' in the same cycle -> halt_cause=0.
- Assert reset low mid-RUN and mid-WAIT_SENT -> all outputs 0 immediately; bp_valid=0; next 'D' produces sendSignal.
